timer_dev: RTL

- Memory-mapped countdown timer that answers CPU bridge accesses in the 0x7f00 and 0x7f10 windows; two instances are placed behind the bridge.
- The bridge supplies a word index plus write strobe and data. It takes read data back combinationally.
- The timer raises an interrupt request toward the CPU's intreq line when the count expires.
- Two modes: one-shot (mode 0) and auto-reload periodic (mode 1).

---
 rtl/timer_dev_pkg.sv | 26 ++
 rtl/timer_dev.sv | 113 +++++++++++
 2 files changed

// File: rtl/timer_dev_pkg.sv
// Shared constants for the memory-mapped countdown timer: FSM encodings,
// register word indices, MODE codes and CTRL bit positions.
package timer_dev_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] IDX_CTRL   = 2'd0;
  localparam logic [1:0] IDX_PRESET = 2'd1;
  localparam logic [1:0] IDX_COUNT  = 2'd2;
  localparam logic [1:0] IDX_RSVD   = 2'd3;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  localparam logic [1:0] CTRL_EN      = 2'd0;
  localparam logic [1:0] CTRL_MODE_LO = 2'd1;
  localparam logic [1:0] CTRL_MODE_HI = 2'd2;
  localparam logic [1:0] CTRL_IM      = 2'd3;

endpackage

// File: rtl/timer_dev.sv
// Countdown timer behind the CPU bridge: CTRL/PRESET/COUNT registers,
// one-shot or periodic countdown, and a maskable interrupt request.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              irq
);

  logic [1:0]        r_state;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_preset;
  logic [CNT_W-1:0]  r_count;
  logic              r_pending;

  logic [1:0]        w_state_nxt;
  logic [CTRL_W-1:0] w_ctrl_nxt;
  logic [CNT_W-1:0]  w_preset_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_pending_nxt;
  logic              w_pend_set;
  logic              w_en;
  logic              w_periodic;
  logic              w_wr_ctrl;
  logic              w_wr_preset;

  assign w_en        = r_ctrl[CTRL_EN];
  assign w_periodic  = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_PERIODIC);
  assign w_wr_ctrl   = we && (addr == IDX_CTRL);
  assign w_wr_preset = we && (addr == IDX_PRESET);

  // FSM and register next-state; bus CTRL write overrides the EN auto-clear,
  // while the FSM setting pending overrides a bus-write clear.
  always_comb begin
    w_state_nxt   = r_state;
    w_ctrl_nxt    = r_ctrl;
    w_preset_nxt  = r_preset;
    w_count_nxt   = r_count;
    w_pending_nxt = r_pending;
    w_pend_set    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_en) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count > CNT_W'(1)) begin
          w_count_nxt = r_count - CNT_W'(1);
        end else begin
          w_count_nxt = '0;
          w_pend_set  = 1'b1;
          w_state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        // Periodic restart passes through IDLE, giving an N+3 cycle period.
        if (w_periodic) w_pending_nxt = 1'b0;
        else            w_ctrl_nxt[CTRL_EN] = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_wr_ctrl)   w_ctrl_nxt   = wd[CTRL_W-1:0];
    if (w_wr_preset) w_preset_nxt = wd[CNT_W-1:0];
    if (w_wr_ctrl || w_wr_preset) w_pending_nxt = 1'b0;
    if (w_pend_set)  w_pending_nxt = 1'b1;
  end

  // State register with synchronous reset that dominates bus writes.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= '0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_preset  <= w_preset_nxt;
      r_count   <= w_count_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      IDX_CTRL:   rd = DATA_W'(r_ctrl);
      IDX_PRESET: rd = DATA_W'(r_preset);
      IDX_COUNT:  rd = DATA_W'(r_count);
      IDX_RSVD:   rd = '0;
      default:    rd = '0;
    endcase
  end

  assign irq = r_ctrl[CTRL_IM] & r_pending;

endmodule
